// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding, decode field positions, PC constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  // Fetch sequencer states: REQ issues, WAIT holds one outstanding fetch,
  // FLUSH swallows the response of a fetch made stale by a redirect.
  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } fetch_state_t;

  // Decode field positions inside the instruction word. The control unit keys
  // on {opcode, dir_mode, inst_type}, so these must stay contiguous from bit 0.
  localparam int INST_TYPE_LSB = 0;
  localparam int INST_TYPE_W   = 2;
  localparam int DIR_MODE_LSB  = 2;
  localparam int DIR_MODE_W    = 2;
  localparam int OPCODE_LSB    = 4;
  localparam int OPCODE_W      = 3;

  // Default PC after reset and the sequential fetch stride in bytes.
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_STEP          = 4;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch: holds the PC, issues one outstanding imem request, registers words into the IF/ID slot.
// Latency: request in cycle N, rvalid in N+L, inst_valid in N+L+1; one instruction per L+1 cycles.
// Backpressure: no new request while the slot is full and id_ready=0; slot outputs hold steady until consumed.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              id_ready,
  output logic [DATA_W-1:0] inst_word,
  output logic [ADDR_W-1:0] inst_pc,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic [1:0]        inst_type,
  output logic [1:0]        dir_mode,
  output logic [2:0]        opcode
);

  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(2'b11);

  fetch_state_t      state_q,      state_d;
  logic [ADDR_W-1:0] pc_q,         pc_d;
  logic              inst_valid_q, inst_valid_d;
  logic [DATA_W-1:0] inst_word_q,  inst_word_d;
  logic [ADDR_W-1:0] inst_pc_q,    inst_pc_d;

  logic              slot_free;
  logic              take_rsp;
  logic [ADDR_W-1:0] redirect_tgt;

  // The slot can accept a new word if it is empty or being drained this cycle.
  assign slot_free = !inst_valid_q || id_ready;

  // Redirect targets are forced word aligned; the low bits are simply masked off.
  assign redirect_tgt = redirect_pc & ALIGN_MASK;

  // A response is captured only in WAIT and only if no redirect makes it stale.
  assign take_rsp = (state_q == WAIT) && imem_rvalid && !redirect;

  // Next-state and request generation. The request is also gated by rst_n so the
  // port reads idle while reset is held, since it is decoded from the state.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    case (state_q)
      REQ: begin
        // A response showing up here has no outstanding request behind it
        // (e.g. a fetch issued before a reset); it is ignored.
        if (rst_n && !redirect && slot_free) begin
          imem_req = 1'b1;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          state_d = REQ;
        end else if (redirect) begin
          state_d = FLUSH;
        end
      end
      FLUSH: begin
        // The stale response ends the flush even if yet another redirect lands
        // in the same cycle; waiting for a second response would deadlock.
        if (imem_rvalid) begin
          state_d = REQ;
        end
      end
      default: begin
        state_d = REQ;
      end
    endcase
  end

  // PC update: redirect wins, otherwise advance past each captured word.
  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_tgt;
    end else if (take_rsp) begin
      pc_d = pc_q + STEP;
    end
  end

  // IF/ID slot: drain on handshake, refill on response, kill on redirect.
  always_comb begin
    inst_valid_d = inst_valid_q;
    inst_word_d  = inst_word_q;
    inst_pc_d    = inst_pc_q;
    if (inst_valid_q && id_ready) begin
      inst_valid_d = 1'b0;
    end
    if (take_rsp) begin
      inst_valid_d = 1'b1;
      inst_word_d  = imem_rdata;
      inst_pc_d    = pc_q;
    end
    if (redirect) begin
      inst_valid_d = 1'b0;
    end
  end

  // State and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // IF/ID output slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_valid_q <= 1'b0;
      inst_word_q  <= '0;
      inst_pc_q    <= '0;
    end else begin
      inst_valid_q <= inst_valid_d;
      inst_word_q  <= inst_word_d;
      inst_pc_q    <= inst_pc_d;
    end
  end

  // The address bus idles at zero whenever no request is being made.
  assign imem_addr  = imem_req ? pc_q : '0;

  assign inst_valid = inst_valid_q;
  assign inst_word  = inst_word_q;
  assign inst_pc    = inst_pc_q;
  assign pc_plus4   = inst_pc_q + STEP;

  // Decode fields are plain slices; consumers qualify them with inst_valid.
  assign inst_type  = inst_word_q[INST_TYPE_LSB +: INST_TYPE_W];
  assign dir_mode   = inst_word_q[DIR_MODE_LSB +: DIR_MODE_W];
  assign opcode     = inst_word_q[OPCODE_LSB +: OPCODE_W];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder with programmable latency,
// scoreboard of expected {pc, word} pushed at request time and popped on consumption.
// Inputs change #1 after posedge; outputs are sampled at negedge.
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        id_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic [31:0] pc_plus4;
  logic [1:0]  inst_type;
  logic [1:0]  dir_mode;
  logic [2:0]  opcode;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  exp_t        exp_inst_q[$];
  logic [31:0] exp_pc = 32'h0;
  int          mem_lat = 1;
  int          req_cnt = 0;
  int          pop_cnt = 0;
  logic [31:0] last_req_addr = 32'h0;
  logic [31:0] last_pop_pc   = 32'h0;
  logic [31:0] last_pop_word = 32'h0;
  logic [31:0] last_pop_pp4  = 32'h0;
  int          pop_cyc_q[$];
  logic [31:0] pop_pc_q[$];

  fetch_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .id_ready    (id_ready),
    .inst_word   (inst_word),
    .inst_pc     (inst_pc),
    .pc_plus4    (pc_plus4),
    .inst_type   (inst_type),
    .dir_mode    (dir_mode),
    .opcode      (opcode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Instruction memory contents: address 0 holds the ADDI key word 0x4.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0004;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory responder and output monitor share one process so their bookkeeping
  // is ordered within each negedge.
  initial begin : responder
    int          pend;
    logic [31:0] pend_addr;
    logic        new_req;
    logic [31:0] new_addr;
    exp_t        e;
    pend = 0;
    pend_addr = 32'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      new_req  = 1'b0;
      new_addr = 32'h0;
      if (rst_n && imem_req) begin
        chk("req_addr", imem_addr, exp_pc);
        chk("one_outstanding", 32'(pend), 32'd0);
        exp_inst_q.push_back('{pc: exp_pc, word: mem_word(exp_pc)});
        exp_pc        = exp_pc + 32'd4;
        new_req       = 1'b1;
        new_addr      = imem_addr;
        last_req_addr = imem_addr;
        req_cnt++;
      end
      if (rst_n && inst_valid) begin
        if (exp_inst_q.size() == 0) begin
          chk("spurious_valid", {31'b0, inst_valid}, 32'd0);
        end else begin
          e = exp_inst_q[0];
          chk("inst_word", inst_word, e.word);
          chk("inst_pc",   inst_pc,   e.pc);
          chk("pc_plus4",  pc_plus4,  e.pc + 32'd4);
          chk("inst_type", 32'(inst_type), 32'(e.word[1:0]));
          chk("dir_mode",  32'(dir_mode),  32'(e.word[3:2]));
          chk("opcode",    32'(opcode),    32'(e.word[6:4]));
          if (id_ready) begin
            void'(exp_inst_q.pop_front());
            last_pop_pc   = inst_pc;
            last_pop_word = inst_word;
            last_pop_pp4  = pc_plus4;
            pop_cyc_q.push_back(cyc);
            pop_pc_q.push_back(inst_pc);
            pop_cnt++;
          end
        end
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (new_req) begin
        pend      = mem_lat;
        pend_addr = new_addr;
      end
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = mem_word(pend_addr);
        end
      end
    end
  end

  // Returns at negedge+#1 of the cycle in which the next request was seen.
  task automatic wait_req(input string tag);
    int base;
    int n;
    base = req_cnt;
    n = 0;
    while (req_cnt == base && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(req_cnt - base), 32'd1);
  endtask

  // Returns at negedge+#1 once pop_cnt has reached target.
  task automatic wait_pops(input int target, input string tag);
    int n;
    n = 0;
    while (pop_cnt < target && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, 32'(pop_cnt >= target), 32'd1);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_inst_valid"}, {31'b0, inst_valid}, 32'd0);
    chk({pfx, "_inst_word"},  inst_word, 32'd0);
    chk({pfx, "_inst_pc"},    inst_pc,   32'd0);
    chk({pfx, "_pc_plus4"},   pc_plus4,  32'd4);
    chk({pfx, "_imem_req"},   {31'b0, imem_req}, 32'd0);
    chk({pfx, "_imem_addr"},  imem_addr, 32'd0);
  endtask

  initial begin : main
    int rel_cyc;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    id_ready    = 1'b0;
    mem_lat     = 1;

    // Reset state.
    repeat (3) @(posedge clk);
    sample();
    check_reset_outputs("rst");

    // First fetch, L=1: request in the first REQ cycle, word two cycles later.
    next_cycle();
    rst_n    = 1'b1;
    id_ready = 1'b1;
    rel_cyc  = cyc;
    sample();
    chk("first_req",  {31'b0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h0);
    sample();
    chk("lat_not_early", {31'b0, inst_valid}, 32'd0);
    sample();
    chk("lat_valid",    {31'b0, inst_valid}, 32'd1);
    chk("first_pc",     inst_pc,  32'h0);
    chk("first_pp4",    pc_plus4, 32'h4);
    chk("first_type",   32'(inst_type), 32'd0);
    chk("first_dir",    32'(dir_mode),  32'd1);
    chk("first_opcode", 32'(opcode),    32'd0);
    chk("second_req",   {31'b0, imem_req}, 32'd1);
    chk("second_addr",  imem_addr, 32'h4);
    chk("first_pop_lat", 32'(pop_cyc_q[0] - rel_cyc), 32'd2);

    // Streaming four words back to back, two cycles apart.
    wait_pops(4, "stream_done");
    for (int i = 0; i < 4; i++) begin
      chk("stream_pc", pop_pc_q[i], 32'(i * 4));
    end
    for (int i = 1; i < 4; i++) begin
      chk("stream_gap", 32'(pop_cyc_q[i] - pop_cyc_q[i-1]), 32'd2);
    end

    // Backpressure: hold a word for five cycles of id_ready=0.
    wait_req("bp_req");
    next_cycle();
    id_ready = 1'b0;
    sample();
    for (int i = 0; i < 4; i++) begin
      sample();
      chk("bp_no_req", {31'b0, imem_req}, 32'd0);
      chk("bp_held",   {31'b0, inst_valid}, 32'd1);
    end
    next_cycle();
    id_ready = 1'b1;
    sample();
    chk("bp_release_req", {31'b0, imem_req}, 32'd1);
    mem_lat = 3;

    // Redirect while waiting: the stale response is dropped, target fetched.
    wait_req("rd_req");
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    void'(exp_inst_q.pop_back());
    exp_pc = 32'h0000_0100;
    next_cycle();
    redirect = 1'b0;
    wait_pops(pop_cnt + 1, "rd_pop");
    chk("rd_target_pc", last_pop_pc, 32'h0000_0100);

    // Redirect in the same cycle as the response.
    wait_req("co_req");
    next_cycle();
    next_cycle();
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    void'(exp_inst_q.pop_back());
    exp_pc = 32'h0000_0200;
    sample();
    chk("co_rvalid", {31'b0, imem_rvalid}, 32'd1);
    next_cycle();
    redirect = 1'b0;
    sample();
    chk("co_no_valid", {31'b0, inst_valid}, 32'd0);
    chk("co_req_now",  {31'b0, imem_req}, 32'd1);
    chk("co_req_addr", imem_addr, 32'h0000_0200);

    // Wrap-around at the top of the address space.
    wait_req("wr_req");
    next_cycle();
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    void'(exp_inst_q.pop_back());
    exp_pc = 32'hFFFF_FFFC;
    next_cycle();
    redirect = 1'b0;
    wait_pops(pop_cnt + 1, "wr_pop");
    chk("wr_pc",   last_pop_pc,  32'hFFFF_FFFC);
    chk("wr_pp4",  last_pop_pp4, 32'h0);
    chk("wr_next", last_req_addr, 32'h0);

    // Reset pulsed mid-fetch; the late response lands in REQ and is ignored.
    wait_req("rs_req");
    next_cycle();
    rst_n = 1'b0;
    exp_inst_q.delete();
    exp_pc = 32'h0;
    sample();
    check_reset_outputs("midrst");
    next_cycle();
    next_cycle();
    rst_n = 1'b1;
    sample();
    chk("rs_late_rvalid", {31'b0, imem_rvalid}, 32'd1);
    chk("rs_req",         {31'b0, imem_req}, 32'd1);
    sample();
    chk("rs_ignored",     {31'b0, inst_valid}, 32'd0);
    wait_pops(pop_cnt + 1, "rs_pop");
    chk("rs_pc",   last_pop_pc,   32'h0);
    chk("rs_word", last_pop_word, 32'h0000_0004);

    repeat (4) sample();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
